// File: rtl/cnt_seq_ctrl_if.sv
// Command/status bundle for cnt_seq_ctrl: the controller side is master, the sequencer is slave.
interface cnt_seq_ctrl_if #(
  parameter int unsigned CNT_W = 2
);
  logic             start_i;
  logic             stop_i;
  logic             step_i;
  logic             clr_i;
  logic [CNT_W-1:0] limit_i;
  logic             wrap_i;
  logic [CNT_W-1:0] count_out;
  logic             tick_o;
  logic [1:0]       state_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, stop_i, step_i, clr_i, limit_i, wrap_i,
    input  count_out, tick_o, state_o, busy_o, done_o
  );

  modport slave (
    input  start_i, stop_i, step_i, clr_i, limit_i, wrap_i,
    output count_out, tick_o, state_o, busy_o, done_o
  );
endinterface

// File: rtl/cnt_seq_ctrl.sv
// Run/pause/step sequencer for a small up-counter, prescaled tick on the 50 MHz clock.
// Define CNT_SEQ_SYNC_EN to synchronise and edge-detect the raw command inputs.
module cnt_seq_ctrl #(
  parameter int unsigned DIV_MAX = 49999999,
  parameter int unsigned DIV_W   = 26,
  parameter int unsigned CNT_W   = 2
) (
  input  logic          clk_50mhz,
  input  logic          rst_50mhz,
  cnt_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             inc;
  logic             start_c, stop_c, step_c, clr_c;
  logic             halt_at_limit;

`ifdef CNT_SEQ_SYNC_EN
  logic [3:0] cmd_raw, cmd_s1, cmd_s2, cmd_prev, cmd_pulse;

  assign cmd_raw = {bus.clr_i, bus.stop_i, bus.start_i, bus.step_i};

  // Two-flop synchroniser, then a registered rising-edge pulse: 3 cycles added latency.
  always_ff @(posedge clk_50mhz or negedge rst_50mhz) begin
    if (!rst_50mhz) begin
      cmd_s1    <= '0;
      cmd_s2    <= '0;
      cmd_prev  <= '0;
      cmd_pulse <= '0;
    end else begin
      cmd_s1    <= cmd_raw;
      cmd_s2    <= cmd_s1;
      cmd_prev  <= cmd_s2;
      cmd_pulse <= cmd_s2 & ~cmd_prev;
    end
  end

  assign {clr_c, stop_c, start_c, step_c} = cmd_pulse;
`else
  assign clr_c   = bus.clr_i;
  assign stop_c  = bus.stop_i;
  assign start_c = bus.start_i;
  assign step_c  = bus.step_i;
`endif

  assign halt_at_limit = (count_q == bus.limit_i) && !bus.wrap_i;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    tick_d  = 1'b0;
    inc     = 1'b0;

    if (clr_c) begin
      state_d = IDLE;
      presc_d = '0;
      count_d = '0;
    end else begin
      // stop outranks start and step even in states where stop itself does nothing
      unique case (state_q)
        IDLE: begin
          if (!stop_c) begin
            if (start_c) begin
              if (halt_at_limit) begin
                state_d = DONE;
              end else begin
                state_d = RUN;
                presc_d = '0;
              end
            end else if (step_c) begin
              inc = 1'b1;
            end
          end
        end
        RUN: begin
          if (stop_c) begin
            state_d = PAUSE;
          end else if (presc_q == DIV_W'(DIV_MAX)) begin
            presc_d = '0;
            inc     = 1'b1;
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end
        PAUSE: begin
          if (!stop_c) begin
            if (start_c) begin
              state_d = halt_at_limit ? DONE : RUN;
            end else if (step_c) begin
              inc = 1'b1;
            end
          end
        end
        DONE: begin
        end
        default: state_d = IDLE;
      endcase

      if (inc) begin
        if (count_q == bus.limit_i) begin
          if (bus.wrap_i) begin
            count_d = '0;
            tick_d  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else begin
          count_d = count_q + CNT_W'(1);
          tick_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_50mhz) begin
    if (!rst_50mhz) begin
      state_q <= IDLE;
      presc_q <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.count_out = count_q;
  assign bus.tick_o    = tick_q;
  assign bus.state_o   = state_q;
  assign bus.busy_o    = (state_q == RUN);
  assign bus.done_o    = (state_q == DONE);

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl (DIV_MAX=3, CNT_W=2, default build); ticks are scored against a queue.
module tb_cnt_seq_ctrl;

  logic clk;
  logic rst_n;
  int unsigned checks;
  int unsigned errors;
  logic [1:0] exp_q[$];
  logic [1:0] exp_v;

  cnt_seq_ctrl_if #(.CNT_W(2)) bus ();

  cnt_seq_ctrl #(.DIV_MAX(3), .DIV_W(2), .CNT_W(2)) dut (
    .clk_50mhz (clk),
    .rst_50mhz (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_cmd(input logic st, input logic sp, input logic sq, input logic cl);
    bus.start_i = st;
    bus.stop_i  = sp;
    bus.step_i  = sq;
    bus.clr_i   = cl;
    cycles(1);
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    bus.step_i  = 1'b0;
    bus.clr_i   = 1'b0;
  endtask

  // Every tick must match the next scheduled count value.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.tick_o === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL tick_sched: observed unscheduled tick count %0h expected no tick", bus.count_out);
      end
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        assert (bus.count_out === exp_v) else begin
          errors++;
          $error("FAIL tick_count: observed %0h expected %0h", bus.count_out, exp_v);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    bus.step_i  = 1'b0;
    bus.clr_i   = 1'b0;
    bus.limit_i = 2'd3;
    bus.wrap_i  = 1'b1;
    #1;
    check("rst_count", 8'(bus.count_out), 8'h0);
    check("rst_state", 8'(bus.state_o), 8'h0);
    check("rst_tick", 8'(bus.tick_o), 8'h0);
    check("rst_busy", 8'(bus.busy_o), 8'h0);
    check("rst_done", 8'(bus.done_o), 8'h0);
    #12 rst_n = 1'b1;
    cycles(2);

    // Wrap run: limit 3, tick every 4 cycles, counts 1,2,3,0,1
    exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    check("run_state", 8'(bus.state_o), 8'h1);
    for (int i = 0; i < 5; i++) begin
      cycles(3);
      check("wrap_notick", 8'(bus.tick_o), 8'h0);
      cycles(1);
      check("wrap_tick", 8'(bus.tick_o), 8'h1);
      check("wrap_busy", 8'(bus.busy_o), 8'h1);
    end

    // Asynchronous reset mid-RUN with count 2
    exp_q.push_back(2'd2);
    cycles(4);
    check("pre_rst_count", 8'(bus.count_out), 8'h2);
    cycles(1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 8'(bus.count_out), 8'h0);
    check("arst_state", 8'(bus.state_o), 8'h0);
    check("arst_tick", 8'(bus.tick_o), 8'h0);
    check("arst_busy", 8'(bus.busy_o), 8'h0);
    check("arst_done", 8'(bus.done_o), 8'h0);
    #3 rst_n = 1'b1;
    cycles(1);
    check("sb_empty_rst", 8'(exp_q.size()), 8'h0);

    // Halt: limit 2, no wrap -> two ticks then DONE holding 2
    bus.limit_i = 2'd2;
    bus.wrap_i  = 1'b0;
    exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    cycles(4);
    check("halt_tick1", 8'(bus.tick_o), 8'h1);
    cycles(4);
    check("halt_tick2", 8'(bus.tick_o), 8'h1);
    cycles(4);
    check("done_state", 8'(bus.state_o), 8'h3);
    check("done_flag", 8'(bus.done_o), 8'h1);
    check("done_busy", 8'(bus.busy_o), 8'h0);
    check("done_tick", 8'(bus.tick_o), 8'h0);
    check("done_count", 8'(bus.count_out), 8'h2);
    pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    pulse_cmd(1'b0, 1'b0, 1'b1, 1'b0);
    cycles(3);
    check("done_hold_state", 8'(bus.state_o), 8'h3);
    check("done_hold_count", 8'(bus.count_out), 8'h2);
    pulse_cmd(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_state", 8'(bus.state_o), 8'h0);
    check("clr_count", 8'(bus.count_out), 8'h0);
    check("clr_done", 8'(bus.done_o), 8'h0);

    // Step while IDLE: increments, state unchanged
    exp_q.push_back(2'd1);
    pulse_cmd(1'b0, 1'b0, 1'b1, 1'b0);
    check("idle_step_tick", 8'(bus.tick_o), 8'h1);
    check("idle_step_state", 8'(bus.state_o), 8'h0);
    pulse_cmd(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr2_count", 8'(bus.count_out), 8'h0);
    check("clr2_tick", 8'(bus.tick_o), 8'h0);

    // Pause with prescaler at 2, two steps, resume -> tick 2 cycles after RUN
    bus.limit_i = 2'd3;
    bus.wrap_i  = 1'b1;
    pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    cycles(2);
    pulse_cmd(1'b0, 1'b1, 1'b0, 1'b0);
    check("pause_state", 8'(bus.state_o), 8'h2);
    check("pause_tick", 8'(bus.tick_o), 8'h0);
    cycles(4);
    check("pause_count", 8'(bus.count_out), 8'h0);
    check("pause_idle_tick", 8'(bus.tick_o), 8'h0);
    exp_q.push_back(2'd1);
    pulse_cmd(1'b0, 1'b0, 1'b1, 1'b0);
    check("pstep1_tick", 8'(bus.tick_o), 8'h1);
    exp_q.push_back(2'd2);
    pulse_cmd(1'b0, 1'b0, 1'b1, 1'b0);
    check("pstep2_tick", 8'(bus.tick_o), 8'h1);
    cycles(1);
    check("pstep_settle", 8'(bus.tick_o), 8'h0);
    exp_q.push_back(2'd3);
    pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    check("resume_state", 8'(bus.state_o), 8'h1);
    check("resume_tick0", 8'(bus.tick_o), 8'h0);
    cycles(1);
    check("resume_tick1", 8'(bus.tick_o), 8'h0);
    cycles(1);
    check("resume_tick2", 8'(bus.tick_o), 8'h1);

    // clr+stop+start together on the cycle an increment is due
    cycles(3);
    bus.clr_i   = 1'b1;
    bus.stop_i  = 1'b1;
    bus.start_i = 1'b1;
    cycles(1);
    bus.clr_i   = 1'b0;
    bus.stop_i  = 1'b0;
    bus.start_i = 1'b0;
    check("prio_state", 8'(bus.state_o), 8'h0);
    check("prio_count", 8'(bus.count_out), 8'h0);
    check("prio_tick", 8'(bus.tick_o), 8'h0);
    check("prio_busy", 8'(bus.busy_o), 8'h0);

    // Held step without synchroniser: one increment per cycle
    exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    bus.step_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      check("held_step_tick", 8'(bus.tick_o), 8'h1);
    end
    bus.step_i = 1'b0;
    cycles(1);
    check("held_step_end", 8'(bus.tick_o), 8'h0);
    check("held_step_count", 8'(bus.count_out), 8'h3);

    // start at limit with no wrap goes straight to DONE without a tick
    bus.wrap_i = 1'b0;
    pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    check("lim_start_state", 8'(bus.state_o), 8'h3);
    check("lim_start_tick", 8'(bus.tick_o), 8'h0);
    check("lim_start_count", 8'(bus.count_out), 8'h3);
    pulse_cmd(1'b0, 1'b0, 1'b0, 1'b1);
    check("final_state", 8'(bus.state_o), 8'h0);
    cycles(2);
    check("sb_empty_end", 8'(exp_q.size()), 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
